// File: rtl/adder_share_arb_if.sv
// adder_share_arb_if: requester/response bundle for the shared-adder arbiter.
// master = client/consumer side, slave = arbiter side.
interface adder_share_arb_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_carry;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
    );
endinterface

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin arbiter sharing one WIDTH-bit adder among NREQ
// requesters; one registered, ID-tagged sum per accept.
// Optional feature macro: ADDER_SHARE_ARB_SAT_EN (clamp rsp_sum to all ones on
// carry-out; rsp_carry still reports the raw carry).
module adder_share_arb #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    adder_share_arb_if.slave   bus
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_last_gnt;
    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

    logic             w_can_accept;
    logic             w_found;
    logic             w_accept;
    logic [IDW-1:0]   w_gnt;
    int unsigned      w_dist;
    int unsigned      w_best;
    logic [NREQ-1:0]  w_ready;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum_full;

    assign w_can_accept = (r_state == ST_IDLE) || bus.rsp_ready;

    // Round-robin pick: valid requester with the smallest distance after last_gnt.
    always_comb begin
        w_gnt   = '0;
        w_found = 1'b0;
        w_best  = NREQ;
        w_dist  = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = (32'(i) + 2 * NREQ - 1 - 32'(r_last_gnt)) % NREQ;
            if (bus.req_valid[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_gnt   = IDW'(i);
                w_found = 1'b1;
            end
        end
    end

    assign w_accept = w_found && w_can_accept && !reset;

    // One-hot ready toward the granted requester; forced low during reset.
    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_ready[i] = w_accept && (w_gnt == IDW'(i));
        end
    end

    // Operand mux feeding the single shared adder.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt == IDW'(i)) begin
                w_a = bus.req_a[i*WIDTH +: WIDTH];
                w_b = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_sum_full = {1'b0, w_a} + {1'b0, w_b};

    // Response FSM and result registers; a new accept in HOLD replaces the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= IDW'(NREQ - 1);
            r_id       <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_state    <= ST_HOLD;
                r_last_gnt <= w_gnt;
                r_id       <= w_gnt;
                r_carry    <= w_sum_full[WIDTH];
`ifdef ADDER_SHARE_ARB_SAT_EN
                r_sum      <= w_sum_full[WIDTH] ? '1 : w_sum_full[WIDTH-1:0];
`else
                r_sum      <= w_sum_full[WIDTH-1:0];
`endif
            end else if ((r_state == ST_HOLD) && bus.rsp_ready) begin
                r_state    <= ST_IDLE;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = (r_state == ST_HOLD);
    assign bus.rsp_id    = r_id;
    assign bus.rsp_sum   = r_sum;
    assign bus.rsp_carry = r_carry;
endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: directed vectors; expected responses queued at issue time
// and checked by an independent monitor when the response is consumed.
module tb_adder_share_arb;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned IDW   = 2;

`ifdef ADDER_SHARE_ARB_SAT_EN
    localparam logic [WIDTH-1:0] OVF_SUM = 16'hFFFF;
`else
    localparam logic [WIDTH-1:0] OVF_SUM = 16'h0001;
`endif

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] sum;
        logic             carry;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];

    // Hand-computed sums for the operand set loaded below.
    exp_t exp_tab [NREQ];

    always #5 clk = ~clk;

    adder_share_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    adder_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.req_a[i*WIDTH +: WIDTH] = a;
        bus.req_b[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every consumed response against the queue head.
    always @(negedge clk) begin
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rsp: got id %0d sum %h with no expected entry", bus.rsp_id, bus.rsp_sum);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_id",    32'(bus.rsp_id),    32'(e.id));
                chk("rsp_sum",   32'(bus.rsp_sum),   32'(e.sum));
                chk("rsp_carry", 32'(bus.rsp_carry), 32'(e.carry));
            end
        end
    end

    initial begin
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;

        exp_tab[0] = '{id: 2'd0, sum: 16'h0011, carry: 1'b0};
        exp_tab[1] = '{id: 2'd1, sum: 16'h0120, carry: 1'b0};
        exp_tab[2] = '{id: 2'd2, sum: 16'h2300, carry: 1'b0};
        exp_tab[3] = '{id: 2'd3, sum: 16'h4004, carry: 1'b0};

        // Reset values; req_ready must stay low during reset even with requests.
        bus.req_valid = 4'b1111;
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_sum",   32'(bus.rsp_sum),   32'd0);
        chk("reset_rsp_id",    32'(bus.rsp_id),    32'd0);
        chk("reset_rsp_carry", 32'(bus.rsp_carry), 32'd0);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
        bus.req_valid = '0;
        step();
        reset = 1'b0;

        // Single request from requester 0.
        bus.rsp_ready = 1'b1;
        set_req(0, 16'h1234, 16'h0101);
        bus.req_valid = 4'b0001;
        q.push_back('{id: 2'd0, sum: 16'h1335, carry: 1'b0});
        @(negedge clk);
        chk("single_req_ready", 32'(bus.req_ready), 32'b0001);
        step();
        bus.req_valid = '0;
        @(negedge clk);
        chk("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        step();

        // All four continuously valid; last grant was 0, so rotation starts at 1.
        set_req(0, 16'h0010, 16'h0001);
        set_req(1, 16'h0100, 16'h0020);
        set_req(2, 16'h2000, 16'h0300);
        set_req(3, 16'h4000, 16'h0004);
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            int g;
            g = (1 + k) % NREQ;
            q.push_back(exp_tab[g]);
            @(negedge clk);
            chk("rr_req_ready", 32'(bus.req_ready), 32'(1 << g));
            step();
        end
        bus.req_valid = '0;
        step();

        // Backpressure on a requester-1 result.
        set_req(1, 16'h00FF, 16'h0001);
        bus.req_valid = 4'b0010;
        q.push_back('{id: 2'd1, sum: 16'h0100, carry: 1'b0});
        step();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1101;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_sum",   32'(bus.rsp_sum),   32'h0100);
            chk("bp_rsp_id",    32'(bus.rsp_id),    32'd1);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            step();
        end
        bus.rsp_ready = 1'b1;
        q.push_back(exp_tab[2]);
        @(negedge clk);
        chk("bp_next_grant", 32'(bus.req_ready), 32'b0100);
        step();
        bus.req_valid = '0;
        step();

        // Overflow on requester 3 (next in rotation after 2).
        set_req(3, 16'hFFFF, 16'h0002);
        bus.req_valid = 4'b1000;
        q.push_back('{id: 2'd3, sum: OVF_SUM, carry: 1'b1});
        @(negedge clk);
        chk("ovf_req_ready", 32'(bus.req_ready), 32'b1000);
        step();
        bus.req_valid = '0;
        step();

        // Reset while holding a result; it must vanish and priority return to 0.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        step();
        bus.req_valid = '0;
        @(negedge clk);
        chk("hold_before_reset", 32'(bus.rsp_valid), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midreset_rsp_sum",   32'(bus.rsp_sum),   32'd0);
        step();
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1001;
        q.push_back(exp_tab[0]);
        @(negedge clk);
        chk("post_reset_priority", 32'(bus.req_ready), 32'b0001);
        step();
        bus.req_valid = '0;
        step();

        // Sparse: requester 2 alone, then requester 0 alone, back to back.
        bus.req_valid = 4'b0100;
        q.push_back(exp_tab[2]);
        @(negedge clk);
        chk("sparse_grant2", 32'(bus.req_ready), 32'b0100);
        step();
        bus.req_valid = 4'b0001;
        q.push_back(exp_tab[0]);
        @(negedge clk);
        chk("sparse_grant0", 32'(bus.req_ready), 32'b0001);
        chk("sparse_b2b_valid", 32'(bus.rsp_valid), 32'd1);
        step();
        bus.req_valid = '0;
        repeat (3) step();

        chk("queue_drained", 32'(q.size()), 32'd0);
        @(negedge clk);
        chk("final_idle", 32'(bus.rsp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
